// File: rtl/hazard_scoreboard.sv
// Producer side of the EX/MEM/WB forwarding interface: shadows dest/RegWrite/MemRead
// per stage and raises stall/flush lines for load-use and branch-in-ID hazards.
module hazard_scoreboard #(
  parameter int REG_ADDR = 5,
  parameter int CNT_W    = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [REG_ADDR-1:0] i_instr_rs_D,
  input  logic [REG_ADDR-1:0] i_instr_rt_D,
  input  logic [REG_ADDR-1:0] i_dest_D,
  input  logic                i_reg_write_D,
  input  logic                i_mem_read_D,
  input  logic                i_branch_D,
  input  logic                i_flush_D,
  output logic [REG_ADDR-1:0] o_instr_rd_E,
  output logic [REG_ADDR-1:0] o_instr_rd_M,
  output logic [REG_ADDR-1:0] o_instr_rd_W,
  output logic                o_reg_write_M,
  output logic                o_reg_write_W,
  output logic                o_stall_F,
  output logic                o_stall_D,
  output logic                o_flush_E,
  output logic [CNT_W-1:0]    o_stall_count
);

  typedef struct packed {
    logic [REG_ADDR-1:0] rd;
    logic                reg_write;
    logic                mem_read;
  } entry_t;

  localparam entry_t BUBBLE = '{rd: {REG_ADDR{1'b0}}, reg_write: 1'b0, mem_read: 1'b0};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  entry_t           ent_e_r, ent_m_r, ent_w_r;
  entry_t           next_e_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             dep_e_s, dep_m_s;
  logic             load_use_s, branch_hz_s, stall_s;

  // Register 0 is hardwired, so a zero source never depends on anything.
  function automatic logic src_hit(input logic [REG_ADDR-1:0] src,
                                   input logic [REG_ADDR-1:0] rd);
    return (src != {REG_ADDR{1'b0}}) && (src == rd);
  endfunction

  // Hazard detection and the next EX entry, from current ID inputs and E/M shadow.
  always_comb begin
    dep_e_s     = ent_e_r.reg_write &
                  (src_hit(i_instr_rs_D, ent_e_r.rd) | src_hit(i_instr_rt_D, ent_e_r.rd));
    dep_m_s     = ent_m_r.reg_write & ent_m_r.mem_read &
                  (src_hit(i_instr_rs_D, ent_m_r.rd) | src_hit(i_instr_rt_D, ent_m_r.rd));
    load_use_s  = ent_e_r.mem_read & dep_e_s;
    branch_hz_s = i_branch_D & (dep_e_s | dep_m_s);
    stall_s     = (load_use_s | branch_hz_s) & i_enable;
    if (stall_s || i_flush_D) begin
      next_e_s = BUBBLE;
    end else begin
      next_e_s = '{rd: i_dest_D, reg_write: i_reg_write_D, mem_read: i_mem_read_D};
    end
  end

  // Pipeline shadow: E/M/W advance together only when enabled.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ent_e_r <= BUBBLE;
      ent_m_r <= BUBBLE;
      ent_w_r <= BUBBLE;
    end else if (i_enable) begin
      ent_e_r <= next_e_s;
      ent_m_r <= ent_e_r;
      ent_w_r <= ent_m_r;
    end else begin
      ent_e_r <= ent_e_r;
      ent_m_r <= ent_m_r;
      ent_w_r <= ent_w_r;
    end
  end

  // Saturating count of stalled cycles for the debug unit.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign o_instr_rd_E  = ent_e_r.rd;
  assign o_instr_rd_M  = ent_m_r.rd;
  assign o_instr_rd_W  = ent_w_r.rd;
  assign o_reg_write_M = ent_m_r.reg_write;
  assign o_reg_write_W = ent_w_r.reg_write;
  // Stall wins over a branch flush: IF/ID holds and the ID instruction retries.
  assign o_stall_F     = stall_s;
  assign o_stall_D     = stall_s;
  assign o_flush_E     = stall_s;
  assign o_stall_count = stall_cnt_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: queue-based pipeline model checked every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_hazard_scoreboard;
  localparam int RA = 5;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset, enable;
  logic [RA-1:0] rs, rt, dest;
  logic          rw, mr, br, fl;
  logic [RA-1:0] rd_e, rd_m, rd_w;
  logic          rw_m, rw_w, st_f, st_d, fl_e;
  logic [CW-1:0] cnt;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  typedef struct {
    logic [RA-1:0] rd;
    bit            w;
    bit            m;
  } ent_t;

  ent_t q[$];   // q[0]=EX, q[1]=MEM, q[2]=WB
  int   m_cnt;

  hazard_scoreboard #(.REG_ADDR(RA), .CNT_W(CW)) dut (
    .i_clk(clk), .i_reset(reset), .i_enable(enable),
    .i_instr_rs_D(rs), .i_instr_rt_D(rt), .i_dest_D(dest),
    .i_reg_write_D(rw), .i_mem_read_D(mr), .i_branch_D(br), .i_flush_D(fl),
    .o_instr_rd_E(rd_e), .o_instr_rd_M(rd_m), .o_instr_rd_W(rd_w),
    .o_reg_write_M(rw_m), .o_reg_write_W(rw_w),
    .o_stall_F(st_f), .o_stall_D(st_d), .o_flush_E(fl_e),
    .o_stall_count(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit reads(input logic [RA-1:0] r);
    return (rs != 0 && rs == r) || (rt != 0 && rt == r);
  endfunction

  function automatic bit model_stall();
    bit lu, bh;
    lu = q[0].m && q[0].w && reads(q[0].rd);
    bh = br && ((q[0].w && reads(q[0].rd)) || (q[1].m && q[1].w && reads(q[1].rd)));
    return (lu || bh) && enable;
  endfunction

  task automatic model_reset();
    ent_t z;
    z = '{rd: 0, w: 0, m: 0};
    q = {z, z, z};
    m_cnt = 0;
  endtask

  // One clock edge; the model advances from the pre-edge inputs.
  task automatic cycle();
    ent_t n;
    bit   s;
    @(posedge clk);
    s = model_stall();
    if (reset) begin
      model_reset();
    end else if (enable) begin
      n = (s || fl) ? '{rd: 0, w: 0, m: 0} : '{rd: dest, w: rw, m: mr};
      q.push_front(n);
      void'(q.pop_back());
      if (s && m_cnt < CMAX) m_cnt++;
    end
    #1;
  endtask

  task automatic drive(input logic [RA-1:0] a_rs, input logic [RA-1:0] a_rt,
                       input logic [RA-1:0] a_dest, input logic a_rw, input logic a_mr,
                       input logic a_br, input logic a_fl);
    rs = a_rs; rt = a_rt; dest = a_dest; rw = a_rw; mr = a_mr; br = a_br; fl = a_fl;
    #1;
  endtask

  task automatic chk_stall(input string name, input logic exp);
    chk({name, "_F"}, st_f, exp);
    chk({name, "_D"}, st_d, exp);
    chk({name, "_flushE"}, fl_e, exp);
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("m_rd_E", rd_e, q[0].rd);
      chk("m_rd_M", rd_m, q[1].rd);
      chk("m_rd_W", rd_w, q[2].rd);
      chk("m_rw_M", rw_m, q[1].w);
      chk("m_rw_W", rw_w, q[2].w);
      chk("m_stall_F", st_f, model_stall());
      chk("m_stall_D", st_d, model_stall());
      chk("m_flush_E", fl_e, model_stall());
      chk("m_count", cnt, m_cnt);
    end
  end

  initial begin
    model_reset();
    reset = 1'b1; enable = 1'b1;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(); cycle();
    reset = 1'b0;
    check_en = 1'b1;
    chk("rst_rd_E", rd_e, 0); chk("rst_rd_W", rd_w, 0); chk("rst_cnt", cnt, 0);

    // load-use: LW r8 then ADD rs=8
    drive(5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0); cycle();
    drive(5'd8, 5'd3, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_stall("lu_stall", 1'b1);
    cycle();
    chk("lu_rd_E", rd_e, 0); chk("lu_rd_M", rd_m, 8); chk("lu_rw_M", rw_m, 1);
    chk_stall("lu_clear", 1'b0); chk("lu_cnt", cnt, 1);
    cycle();
    chk("lu_add_E", rd_e, 11);

    // branch on load in EX: two stall cycles
    drive(5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0); cycle();
    drive(5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_stall("bl_s1", 1'b1);
    cycle();
    chk_stall("bl_s2", 1'b1);
    cycle();
    chk_stall("bl_go", 1'b0); chk("bl_rd_W", rd_w, 9); chk("bl_cnt", cnt, 3);
    cycle();

    // branch on ALU result in EX: one stall; r0 never stalls
    drive(5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
    drive(5'd1, 5'd10, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_stall("ba_s1", 1'b1);
    cycle();
    chk_stall("ba_go", 1'b0); chk("ba_cnt", cnt, 4);
    cycle();
    drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_stall("b0_none", 1'b0);
    cycle();

    // flush without and with a load-use hazard
    drive(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1); cycle();
    chk("fl_rd_E", rd_e, 0);
    drive(5'd0, 5'd0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0); cycle();
    drive(5'd12, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_stall("fl_lu", 1'b1);
    cycle();
    chk("fl_cnt", cnt, 5);
    cycle();

    // freeze during an active load-use
    drive(5'd0, 5'd0, 5'd13, 1'b1, 1'b1, 1'b0, 1'b0); cycle();
    enable = 1'b0;
    drive(5'd13, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_stall("frz_off", 1'b0);
    cycle(); cycle(); cycle();
    chk("frz_rd_E", rd_e, 13); chk("frz_cnt", cnt, 5);
    enable = 1'b1; #1;
    chk_stall("frz_resume", 1'b1);
    cycle();
    chk_stall("frz_done", 1'b0); chk("frz_cnt2", cnt, 6);

    // reset mid-stream with E/M/W all valid and a hazard pending
    drive(5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
    drive(5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
    drive(5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0); cycle();
    chk("mid_rd_E", rd_e, 3); chk("mid_rd_M", rd_m, 2); chk("mid_rd_W", rd_w, 1);
    reset = 1'b1;
    drive(5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    reset = 1'b0; #1;
    chk("mr_rd_E", rd_e, 0); chk("mr_rd_M", rd_m, 0); chk("mr_rd_W", rd_w, 0);
    chk("mr_rw_M", rw_m, 0); chk("mr_rw_W", rw_w, 0); chk("mr_cnt", cnt, 0);
    chk_stall("mr_stall", 1'b0);

    // saturation: a self-dependent load stalls every other cycle
    drive(5'd8, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2 * (CMAX + 1) + 6; i++) cycle();
    chk("sat_cnt", cnt, CMAX);

    @(negedge clk);
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
